// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, the load/store requester and the shared
//   memory port of mem_port_arbiter.
//   Handshake: a requester raises *_req with its address and controls and
//   holds them stable until the arbiter answers with *_gnt in the same cycle
//   (combinational). Every grant produces exactly one *_rvalid pulse in the
//   following cycle; no pulse occurs without a grant.
//   Modports:
//     slave  - the arbiter: takes requests and mem_rdata, drives grants,
//              responses and memory strobes.
//     master - the surrounding system (core requesters plus memory).
interface mem_port_arbiter_if;
  // instruction fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // load/store requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [2:0]  d_func3;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  // shared memory port
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_func3, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_read, mem_write, mem_addr, mem_func3, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_func3, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_read, mem_write, mem_addr, mem_func3, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port byte-addressable memory between instruction fetch
//   and load/store. At most one grant per cycle; grants and strobes are
//   combinational, responses are registered (one-cycle latency). Illegal data
//   accesses (bad func3, misaligned, out of range) are granted but never
//   reach memory; they answer with d_err=1 and d_rdata=0.
//   A starvation counter lets fetch win one contended cycle after STARVE_MAX
//   consecutive denied fetch cycles.
//   Ports:
//     clk, rst      - clock, synchronous active-high reset
//     bus           - mem_port_arbiter_if.slave (requests, responses, memory)
//     o_state       - debug: current priority state (0 = DATA_PRI, 1 = IF_PRI)
//     o_starve_cnt  - debug: starvation counter
module mem_port_arbiter #(
  parameter int MEM_BYTES  = 4096,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_port_arbiter_if.slave        bus,
  output logic                     o_state,
  output logic [3:0]               o_starve_cnt
);

  typedef enum logic {DATA_PRI = 1'b0, IF_PRI = 1'b1} state_t;

  localparam logic [32:0] MEM_LIMIT  = 33'(MEM_BYTES);
  localparam logic [31:0] ADDR_MASK  = 32'(MEM_BYTES - 1);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  state_t      r_state, w_state_next;
  logic [3:0]  r_starve_cnt, w_starve_next;
  logic        w_if_gnt, w_d_gnt;
  logic        w_func3_ok, w_align_ok, w_range_ok, w_d_legal;
  logic [1:0]  w_size_m1;
  logic [32:0] w_last;

  logic        r_if_rvalid, r_d_rvalid, r_d_err;
  logic [31:0] r_if_rdata, r_d_rdata;

  // Data legality. w_size_m1 is access size minus one (0, 1 or 3), which
  // doubles as the mask of address bits that must be zero for alignment.
  always_comb begin
    w_size_m1  = 2'd0;
    w_func3_ok = 1'b0;
    case (bus.d_func3)
      3'b000: begin w_size_m1 = 2'd0; w_func3_ok = 1'b1;      end
      3'b001: begin w_size_m1 = 2'd1; w_func3_ok = 1'b1;      end
      3'b010: begin w_size_m1 = 2'd3; w_func3_ok = 1'b1;      end
      3'b100: begin w_size_m1 = 2'd0; w_func3_ok = !bus.d_we; end
      3'b101: begin w_size_m1 = 2'd1; w_func3_ok = !bus.d_we; end
      default: ;
    endcase
    w_align_ok = (bus.d_addr[1:0] & w_size_m1) == 2'b00;
    // 33-bit sum so an address near 2^32 cannot wrap into range
    w_last     = {1'b0, bus.d_addr} + {31'b0, w_size_m1};
    w_range_ok = w_last < MEM_LIMIT;
    w_d_legal  = w_func3_ok && w_align_ok && w_range_ok;
  end

  // Grants, memory drive, starvation counter and priority FSM
  always_comb begin
    w_if_gnt      = 1'b0;
    w_d_gnt       = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_func3 = '0;
    bus.mem_wdata = '0;
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;

    if (!rst) begin
      if (bus.if_req && (!bus.d_req || r_state == IF_PRI)) w_if_gnt = 1'b1;
      else if (bus.d_req)                                    w_d_gnt  = 1'b1;
    end

    if (w_if_gnt) begin
      bus.mem_read  = 1'b1;
      bus.mem_func3 = 3'b010;
      bus.mem_addr  = bus.if_addr & ~32'd3 & ADDR_MASK;
    end else if (w_d_gnt && w_d_legal) begin
      bus.mem_read  = !bus.d_we;
      bus.mem_write = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_func3 = bus.d_func3;
      bus.mem_wdata = bus.d_wdata;
    end

    if (!bus.if_req || w_if_gnt)        w_starve_next = '0;
    else if (r_starve_cnt != STARVE_LIM) w_starve_next = r_starve_cnt + 4'd1;

    // Switch on the count being registered this cycle, so the first cycle
    // that sees STARVE_MAX denials is already a fetch-priority cycle.
    case (r_state)
      DATA_PRI: if (w_starve_next == STARVE_LIM) w_state_next = IF_PRI;
      IF_PRI:   if (w_if_gnt)                    w_state_next = DATA_PRI;
      default:                                   w_state_next = DATA_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= DATA_PRI;
      r_starve_cnt <= '0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rvalid   <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      r_if_rvalid  <= w_if_gnt;
      r_if_rdata   <= w_if_gnt ? bus.mem_rdata : '0;
      r_d_rvalid   <= w_d_gnt;
      r_d_err      <= w_d_gnt && !w_d_legal;
      r_d_rdata    <= (w_d_gnt && w_d_legal && !bus.d_we) ? bus.mem_rdata : '0;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_err     = r_d_err;
  assign o_state       = r_state;
  assign o_starve_cnt  = r_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a 4 KiB byte memory model.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       dbg_state;
  logic [3:0] dbg_cnt;
  int         n_tests = 0;
  int         n_fail  = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_BYTES(4096), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .o_state      (dbg_state),
    .o_starve_cnt (dbg_cnt)
  );

  // clock
  always #5 clk = ~clk;

  // memory model: combinational read with width/sign from mem_func3
  logic [7:0]  mem [0:4095];
  logic [11:0] rd_a;
  logic [7:0]  b0, b1, b2, b3;

  always_comb begin
    rd_a = bus.mem_addr[11:0];
    b0 = mem[rd_a];
    b1 = mem[rd_a + 12'd1];
    b2 = mem[rd_a + 12'd2];
    b3 = mem[rd_a + 12'd3];
    bus.mem_rdata = '0;
    if (bus.mem_read) begin
      case (bus.mem_func3)
        3'b000: bus.mem_rdata = {{24{b0[7]}}, b0};
        3'b001: bus.mem_rdata = {{16{b1[7]}}, b1, b0};
        3'b010: bus.mem_rdata = {b3, b2, b1, b0};
        3'b100: bus.mem_rdata = {24'b0, b0};
        3'b101: bus.mem_rdata = {16'b0, b1, b0};
        default: bus.mem_rdata = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (bus.mem_write) begin
      case (bus.mem_func3)
        3'b000: mem[rd_a] = bus.mem_wdata[7:0];
        3'b001: begin
          mem[rd_a]         = bus.mem_wdata[7:0];
          mem[rd_a + 12'd1] = bus.mem_wdata[15:8];
        end
        default: begin
          mem[rd_a]         = bus.mem_wdata[7:0];
          mem[rd_a + 12'd1] = bus.mem_wdata[15:8];
          mem[rd_a + 12'd2] = bus.mem_wdata[23:16];
          mem[rd_a + 12'd3] = bus.mem_wdata[31:24];
        end
      endcase
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data transaction: request, check grant/strobes mid-cycle, then the
  // response one cycle later.
  task automatic data_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_strobe, input logic exp_err,
                          input logic [31:0] exp_rdata);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_func3 = f3;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    @(negedge clk);
    check_eq({tag, " d_gnt"},     32'(bus.d_gnt), 32'd1);
    check_eq({tag, " if_gnt"},    32'(bus.if_gnt), 32'd0);
    check_eq({tag, " mem_read"},  32'(bus.mem_read),  32'(exp_strobe && !we));
    check_eq({tag, " mem_write"}, 32'(bus.mem_write), 32'(exp_strobe && we));
    check_eq({tag, " mem_addr"},  bus.mem_addr, exp_strobe ? addr : 32'd0);
    tick();
    bus.d_req = 1'b0;
    check_eq({tag, " d_rvalid"}, 32'(bus.d_rvalid), 32'd1);
    check_eq({tag, " d_err"},    32'(bus.d_err), 32'(exp_err));
    check_eq({tag, " d_rdata"},  bus.d_rdata, exp_rdata);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[16'h10] = 8'h13;
    mem[16'h11] = 8'h00;
    mem[16'h12] = 8'h50;
    mem[16'h13] = 8'h00;

    // reset with both requesters active
    rst         = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_func3 = 3'b010;
    bus.d_addr  = 32'h300;
    bus.d_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    check_eq("rst if_gnt",    32'(bus.if_gnt), 32'd0);
    check_eq("rst d_gnt",     32'(bus.d_gnt), 32'd0);
    check_eq("rst mem_read",  32'(bus.mem_read), 32'd0);
    check_eq("rst mem_write", 32'(bus.mem_write), 32'd0);
    tick();
    tick();
    check_eq("rst if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check_eq("rst d_rvalid",  32'(bus.d_rvalid), 32'd0);
    check_eq("rst d_err",     32'(bus.d_err), 32'd0);
    check_eq("rst if_rdata",  bus.if_rdata, 32'd0);
    check_eq("rst d_rdata",   bus.d_rdata, 32'd0);
    check_eq("rst state",     32'(dbg_state), 32'd0);
    check_eq("rst cnt",       32'(dbg_cnt), 32'd0);
    rst        = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    check_eq("post-rst if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check_eq("post-rst d_rvalid",  32'(bus.d_rvalid), 32'd0);
    check_eq("rst no write 0x300", mem_word(32'h300), 32'd0);

    // fetch only
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h12;
    @(negedge clk);
    check_eq("fetch if_gnt",    32'(bus.if_gnt), 32'd1);
    check_eq("fetch d_gnt",     32'(bus.d_gnt), 32'd0);
    check_eq("fetch mem_addr",  bus.mem_addr, 32'h10);
    check_eq("fetch mem_read",  32'(bus.mem_read), 32'd1);
    check_eq("fetch mem_func3", 32'(bus.mem_func3), 32'd2);
    tick();
    bus.if_req = 1'b0;
    check_eq("fetch if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check_eq("fetch if_rdata",  bus.if_rdata, 32'h00500013);
    check_eq("fetch d_rvalid",  32'(bus.d_rvalid), 32'd0);
    tick();
    check_eq("fetch pulse end", 32'(bus.if_rvalid), 32'd0);

    // fetch address with high bits set is masked to the memory size
    bus.if_req  = 1'b1;
    bus.if_addr = 32'hFFFF_F013;
    @(negedge clk);
    check_eq("fetch mask mem_addr", bus.mem_addr, 32'h10);
    tick();
    bus.if_req = 1'b0;
    check_eq("fetch mask if_rdata", bus.if_rdata, 32'h00500013);

    // store, then sign/zero-extended byte loads
    data_txn("SW 0x100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    check_eq("SW memory", mem_word(32'h100), 32'hDEADBEEF);
    data_txn("LB 0x103",  1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 1'b0, 32'hFFFFFFDE);
    data_txn("LBU 0x103", 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 1'b0, 32'h000000DE);
    data_txn("LH 0x102",  1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 1'b0, 32'hFFFFDEAD);
    data_txn("LHU 0x100", 1'b0, 3'b101, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0000BEEF);

    // rejected accesses and range boundaries
    data_txn("LW 0x102 misalign", 1'b0, 3'b010, 32'h102,  32'h0, 1'b0, 1'b1, 32'h0);
    data_txn("SH 0xFFF",          1'b1, 3'b001, 32'hFFF,  32'h1234, 1'b0, 1'b1, 32'h0);
    data_txn("S f3=100",          1'b1, 3'b100, 32'h104,  32'h55, 1'b0, 1'b1, 32'h0);
    data_txn("LW 0x1000 range",   1'b0, 3'b010, 32'h1000, 32'h0, 1'b0, 1'b1, 32'h0);
    data_txn("L f3=011",          1'b0, 3'b011, 32'h100,  32'h0, 1'b0, 1'b1, 32'h0);
    data_txn("LW 0xFFC edge",     1'b0, 3'b010, 32'hFFC,  32'h0, 1'b1, 1'b0, 32'h0);
    data_txn("LH 0xFFE edge",     1'b0, 3'b001, 32'hFFE,  32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("SH 0xFFF no write", {24'b0, mem[12'hFFF]}, 32'h0);
    check_eq("S f3=100 no write", mem_word(32'h104), 32'h0);

    // contention: 4 data grants then 1 fetch grant, twice
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_func3 = 3'b010;
    bus.d_addr  = 32'h100;
    for (int k = 0; k < 10; k++) begin
      logic exp_if;
      exp_if = (k % 5) == 4;
      @(negedge clk);
      check_eq($sformatf("cont%0d if_gnt", k), 32'(bus.if_gnt), 32'(exp_if));
      check_eq($sformatf("cont%0d d_gnt", k),  32'(bus.d_gnt), 32'(!exp_if));
      tick();
      check_eq($sformatf("cont%0d if_rvalid", k), 32'(bus.if_rvalid), 32'(exp_if));
      check_eq($sformatf("cont%0d d_rvalid", k),  32'(bus.d_rvalid), 32'(!exp_if));
      if (exp_if) check_eq($sformatf("cont%0d if_rdata", k), bus.if_rdata, 32'h00500013);
      else        check_eq($sformatf("cont%0d d_rdata", k),  bus.d_rdata, 32'hDEADBEEF);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check_eq("cont state back", 32'(dbg_state), 32'd0);

    // reset asserted in the cycle of a store request
    rst         = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_func3 = 3'b010;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'h12345678;
    @(negedge clk);
    check_eq("rst-mid d_gnt",     32'(bus.d_gnt), 32'd0);
    check_eq("rst-mid mem_write", 32'(bus.mem_write), 32'd0);
    tick();
    rst       = 1'b0;
    bus.d_req = 1'b0;
    check_eq("rst-mid d_rvalid",  32'(bus.d_rvalid), 32'd0);
    tick();
    check_eq("rst-mid d_rvalid2", 32'(bus.d_rvalid), 32'd0);
    check_eq("rst-mid memory",    mem_word(32'h200), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
